// File: rtl/otter_tmr_pkg.sv
// Shared definitions for the OTTER IOBUS countdown timer: register offsets,
// CTRL field positions and the timer FSM state type.
package otter_tmr_pkg;

  // Byte offsets inside the 32-byte register window
  localparam logic [4:0] OFS_CTRL   = 5'h00;
  localparam logic [4:0] OFS_LOAD   = 5'h04;
  localparam logic [4:0] OFS_COUNT  = 5'h08;
  localparam logic [4:0] OFS_STATUS = 5'h0C;
  localparam logic [4:0] OFS_CMP    = 5'h10;

  // CTRL bit positions; PRESCALE occupies PRESCALE_W bits from CTRL_PRESCALE_LSB
  localparam int CTRL_EN           = 0;
  localparam int CTRL_AUTO_RELOAD  = 1;
  localparam int CTRL_IRQ_EN       = 2;
  localparam int CTRL_PRESCALE_LSB = 8;

  localparam int STATUS_EXPIRED = 0;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } tmr_state_t;

endpackage

// File: rtl/otter_iobus_timer_if.sv
// OTTER memory-stage IOBUS as seen by one responder: address, write data and
// write strobe from the CPU, combinational read data back to it.
interface otter_iobus_timer_if;

  logic [31:0] IOBUS_ADDR;
  logic [31:0] IOBUS_OUT;
  logic        IOBUS_WR;
  logic [31:0] IOBUS_IN;

  modport master (
    output IOBUS_ADDR,
    output IOBUS_OUT,
    output IOBUS_WR,
    input  IOBUS_IN
  );

  modport slave (
    input  IOBUS_ADDR,
    input  IOBUS_OUT,
    input  IOBUS_WR,
    output IOBUS_IN
  );

endinterface

// File: rtl/tmr_prescaler.sv
// Prescale counter for the OTTER timer: counts while running and emits a
// one-cycle tick every (prescale+1) cycles; clear restarts the period.
module tmr_prescaler #(
  parameter int PRESCALE_W = 8
) (
  input  logic                  CLOCK,
  input  logic                  RESET,
  input  logic                  run,
  input  logic                  clear,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  tick
);

  logic [PRESCALE_W-1:0] cnt_r;

  // >= rather than == so lowering PRESCALE mid-period cannot strand the counter
  assign tick = run & ~clear & (cnt_r >= prescale);

  // Prescale counter: cleared on restart, wraps on tick, holds while stopped
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (clear || tick) begin
      cnt_r <= {PRESCALE_W{1'b0}};
    end else if (run) begin
      cnt_r <= cnt_r + {{(PRESCALE_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/otter_iobus_timer.sv
// Memory-mapped countdown timer on the OTTER IOBUS with one-shot/auto-reload
// modes and an interrupt. Define OTTER_TMR_PWM_EN to add the CMP register and PWM_OUT.
module otter_iobus_timer
  import otter_tmr_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          PRESCALE_W = 8,
  parameter int          COUNT_W    = 32
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  otter_iobus_timer_if.slave   iobus,
  output logic                 INTR,
  output logic                 PWM_OUT
);

  tmr_state_t state_r;
  tmr_state_t state_nxt_s;

  logic                  en_r;
  logic                  auto_r;
  logic                  irq_en_r;
  logic [PRESCALE_W-1:0] prescale_r;
  logic [COUNT_W-1:0]    load_r;
  logic [COUNT_W-1:0]    count_r;
  logic                  expired_r;

  logic [31:0] wdata_s;
  logic [4:0]  ofs_s;
  logic        hit_s;
  logic        wr_hit_s;
  logic        ctrl_wr_s;
  logic        load_wr_s;
  logic        count_wr_s;
  logic        status_wr_s;
  logic        start_s;
  logic        run_s;
  logic        tick_s;
  logic        psc_clear_s;
  logic        expire_s;
  logic        oneshot_exp_s;
  logic [31:0] rdata_s;
  logic        unused_s;

  assign wdata_s     = iobus.IOBUS_OUT;
  assign hit_s       = (iobus.IOBUS_ADDR[31:5] == BASE_ADDR[31:5]);
  assign ofs_s       = {iobus.IOBUS_ADDR[4:2], 2'b00};
  assign wr_hit_s    = iobus.IOBUS_WR & hit_s;
  assign ctrl_wr_s   = wr_hit_s & (ofs_s == OFS_CTRL);
  assign load_wr_s   = wr_hit_s & (ofs_s == OFS_LOAD);
  assign count_wr_s  = wr_hit_s & (ofs_s == OFS_COUNT);
  assign status_wr_s = wr_hit_s & (ofs_s == OFS_STATUS);
  assign unused_s    = ^{iobus.IOBUS_ADDR[1:0], wdata_s};

  assign start_s       = ctrl_wr_s & wdata_s[CTRL_EN] & ~en_r;
  assign expire_s      = tick_s & (count_r == {COUNT_W{1'b0}});
  assign oneshot_exp_s = expire_s & ~auto_r;
  // A COUNT write restarts the prescale period and suppresses the racing tick
  assign psc_clear_s   = start_s | count_wr_s;

  tmr_prescaler #(
    .PRESCALE_W (PRESCALE_W)
  ) u_prescaler (
    .CLOCK    (CLOCK),
    .RESET    (RESET),
    .run      (run_s),
    .clear    (psc_clear_s),
    .prescale (prescale_r),
    .tick     (tick_s)
  );

  // FSM state register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state: start on EN rising, stop on EN cleared or one-shot expiry
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (ctrl_wr_s && !wdata_s[CTRL_EN]) begin
          state_nxt_s = IDLE;
        end else if (oneshot_exp_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    run_s = 1'b0;
    case (state_r)
      IDLE:    run_s = 1'b0;
      RUN:     run_s = 1'b1;
      default: run_s = 1'b0;
    endcase
  end

  // CTRL fields; one-shot expiry clears EN so firmware sees the timer stopped
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      en_r       <= 1'b0;
      auto_r     <= 1'b0;
      irq_en_r   <= 1'b0;
      prescale_r <= {PRESCALE_W{1'b0}};
    end else begin
      if (ctrl_wr_s) begin
        auto_r     <= wdata_s[CTRL_AUTO_RELOAD];
        irq_en_r   <= wdata_s[CTRL_IRQ_EN];
        prescale_r <= wdata_s[CTRL_PRESCALE_LSB +: PRESCALE_W];
      end
      if (oneshot_exp_s) begin
        en_r <= 1'b0;
      end else if (ctrl_wr_s) begin
        en_r <= wdata_s[CTRL_EN];
      end
    end
  end

  // LOAD register; a write while running only affects the next reload
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      load_r <= {COUNT_W{1'b0}};
    end else if (load_wr_s) begin
      load_r <= wdata_s[COUNT_W-1:0];
    end
  end

  // COUNT register: firmware write beats start, start beats tick
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      count_r <= {COUNT_W{1'b0}};
    end else if (count_wr_s) begin
      count_r <= wdata_s[COUNT_W-1:0];
    end else if (start_s) begin
      count_r <= load_r;
    end else if (tick_s) begin
      if (count_r != {COUNT_W{1'b0}}) begin
        count_r <= count_r - COUNT_W'(1);
      end else if (auto_r) begin
        count_r <= load_r;
      end
    end
  end

  // Sticky EXPIRED flag; a new expiry wins over a simultaneous W1C
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      expired_r <= 1'b0;
    end else if (expire_s) begin
      expired_r <= 1'b1;
    end else if (status_wr_s && wdata_s[STATUS_EXPIRED]) begin
      expired_r <= 1'b0;
    end
  end

  assign INTR = expired_r & irq_en_r;

`ifdef OTTER_TMR_PWM_EN
  logic [COUNT_W-1:0] cmp_r;

  // Compare register for the PWM output
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cmp_r <= {COUNT_W{1'b0}};
    end else if (wr_hit_s && (ofs_s == OFS_CMP)) begin
      cmp_r <= wdata_s[COUNT_W-1:0];
    end
  end

  assign PWM_OUT = run_s & (count_r < cmp_r);
`else
  assign PWM_OUT = 1'b0;
`endif

  // Readback mux: zero on a miss or an unmapped offset
  always_comb begin
    rdata_s = 32'h0000_0000;
    if (hit_s) begin
      case (ofs_s)
        OFS_CTRL: begin
          rdata_s[CTRL_EN]          = en_r;
          rdata_s[CTRL_AUTO_RELOAD] = auto_r;
          rdata_s[CTRL_IRQ_EN]      = irq_en_r;
          rdata_s[CTRL_PRESCALE_LSB +: PRESCALE_W] = prescale_r;
        end
        OFS_LOAD:   rdata_s[COUNT_W-1:0] = load_r;
        OFS_COUNT:  rdata_s[COUNT_W-1:0] = count_r;
        OFS_STATUS: rdata_s[STATUS_EXPIRED] = expired_r;
`ifdef OTTER_TMR_PWM_EN
        OFS_CMP:    rdata_s[COUNT_W-1:0] = cmp_r;
`endif
        default:    rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  assign iobus.IOBUS_IN = rdata_s;

endmodule

// File: tb/tb_otter_iobus_timer.sv
// Directed scoreboard bench for otter_iobus_timer; honours OTTER_TMR_PWM_EN
// to pick the compare-output checks.
module tb_otter_iobus_timer;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam logic [31:0] A_CTRL   = BASE + 32'h00;
  localparam logic [31:0] A_LOAD   = BASE + 32'h04;
  localparam logic [31:0] A_COUNT  = BASE + 32'h08;
  localparam logic [31:0] A_STATUS = BASE + 32'h0C;
  localparam logic [31:0] A_CMP    = BASE + 32'h10;

  localparam int K_RD   = 0;
  localparam int K_INTR = 1;
  localparam int K_PWM  = 2;

  typedef struct {
    int          kind;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic CLOCK;
  logic RESET;
  logic INTR;
  logic PWM_OUT;
  logic chk_strobe;

  item_t sb_q[$];
  int    n_tests;
  int    n_fail;

  otter_iobus_timer_if bus();

  otter_iobus_timer dut (
    .CLOCK   (CLOCK),
    .RESET   (RESET),
    .iobus   (bus),
    .INTR    (INTR),
    .PWM_OUT (PWM_OUT)
  );

  initial begin
    CLOCK = 1'b0;
    forever #5 CLOCK = ~CLOCK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Monitor: each strobe pops one expectation and compares the presented output
  initial begin
    item_t       it;
    logic [31:0] act;
    n_tests = 0;
    n_fail  = 0;
    forever begin
      @(posedge chk_strobe);
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: got strobe expected queued item");
      end else begin
        it = sb_q.pop_front();
        case (it.kind)
          K_RD:    act = bus.IOBUS_IN;
          K_INTR:  act = {31'd0, INTR};
          K_PWM:   act = {31'd0, PWM_OUT};
          default: act = 32'hxxxx_xxxx;
        endcase
        n_tests++;
        if (act !== it.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic push_and_strobe(input int kind, input logic [31:0] e, input string nm);
    item_t it;
    it.kind = kind;
    it.exp  = e;
    it.name = nm;
    sb_q.push_back(it);
    chk_strobe = 1'b1;
    #1;
    chk_strobe = 1'b0;
  endtask

  task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] e);
    bus.IOBUS_ADDR = a;
    #1;
    push_and_strobe(K_RD, e, nm);
  endtask

  task automatic chk_pin(input string nm, input int kind, input logic e);
    #1;
    push_and_strobe(kind, {31'd0, e}, nm);
  endtask

  // Called just after a falling edge; the write lands on the next rising edge
  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    bus.IOBUS_ADDR = a;
    bus.IOBUS_OUT  = d;
    bus.IOBUS_WR   = 1'b1;
    @(negedge CLOCK);
    bus.IOBUS_WR   = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge CLOCK);
  endtask

  initial begin
    chk_strobe     = 1'b0;
    RESET          = 1'b0;
    bus.IOBUS_ADDR = 32'h0;
    bus.IOBUS_OUT  = 32'h0;
    bus.IOBUS_WR   = 1'b0;
    step(2);
    chk_rd("rst_ctrl", A_CTRL, 32'h0);
    chk_pin("rst_intr", K_INTR, 1'b0);
    RESET = 1'b1;
    step(1);

    // Asynchronous reset while running with INTR asserted
    bus_wr(A_LOAD, 32'd2);
    bus_wr(A_CTRL, 32'h0000_0007);
    step(3);
    chk_pin("t1_intr_pre", K_INTR, 1'b1);
    chk_rd("t1_count_pre", A_COUNT, 32'd2);
    step(1);
    #2;
    RESET = 1'b0;
    chk_rd("t1_count_rst", A_COUNT, 32'd0);
    chk_pin("t1_intr_rst", K_INTR, 1'b0);
    chk_pin("t1_pwm_rst", K_PWM, 1'b0);
    chk_rd("t1_ctrl_rst", A_CTRL, 32'd0);
    chk_rd("t1_load_rst", A_LOAD, 32'd0);
    chk_rd("t1_status_rst", A_STATUS, 32'd0);
    step(1);
    RESET = 1'b1;
    step(1);

    // One-shot, PRESCALE=0
    bus_wr(A_LOAD, 32'd3);
    bus_wr(A_CTRL, 32'h0000_0005);
    chk_rd("t2_count3", A_COUNT, 32'd3);
    chk_rd("t2_status0", A_STATUS, 32'd0);
    step(1);
    chk_rd("t2_count2", A_COUNT, 32'd2);
    step(1);
    chk_rd("t2_count1", A_COUNT, 32'd1);
    step(1);
    chk_rd("t2_count0", A_COUNT, 32'd0);
    chk_pin("t2_intr_early", K_INTR, 1'b0);
    step(1);
    chk_rd("t2_expired", A_STATUS, 32'd1);
    chk_pin("t2_intr", K_INTR, 1'b1);
    step(1);
    chk_rd("t2_ctrl_en0", A_CTRL, 32'h0000_0004);
    chk_rd("t2_count_hold", A_COUNT, 32'd0);
    bus_wr(A_STATUS, 32'd1);
    chk_rd("t2_w1c", A_STATUS, 32'd0);
    chk_pin("t2_intr_clr", K_INTR, 1'b0);

    // Auto-reload, PRESCALE=2
    bus_wr(A_LOAD, 32'd1);
    bus_wr(A_CTRL, 32'h0000_0203);
    chk_rd("t3_c_e0", A_COUNT, 32'd1);
    chk_rd("t3_st_e0", A_STATUS, 32'd0);
    step(1);
    chk_rd("t3_c_e1", A_COUNT, 32'd1);
    step(1);
    chk_rd("t3_c_e2", A_COUNT, 32'd1);
    step(1);
    chk_rd("t3_c_e3", A_COUNT, 32'd0);
    step(1);
    chk_rd("t3_c_e4", A_COUNT, 32'd0);
    step(1);
    chk_rd("t3_c_e5", A_COUNT, 32'd0);
    chk_rd("t3_st_e5", A_STATUS, 32'd0);
    step(1);
    chk_rd("t3_c_e6", A_COUNT, 32'd1);
    chk_rd("t3_st_e6", A_STATUS, 32'd1);

    // W1C racing the next expiry; EN 1->1 rewrite turns on IRQ_EN only
    bus_wr(A_STATUS, 32'd1);
    chk_rd("t4_clr_e7", A_STATUS, 32'd0);
    bus_wr(A_CTRL, 32'h0000_0207);
    chk_rd("t4_c_e8", A_COUNT, 32'd1);
    chk_rd("t4_ctrl", A_CTRL, 32'h0000_0207);
    step(3);
    chk_rd("t4_c_e11", A_COUNT, 32'd0);
    bus_wr(A_STATUS, 32'd1);
    chk_rd("t4_race_set", A_STATUS, 32'd1);
    chk_pin("t4_race_intr", K_INTR, 1'b1);
    bus_wr(A_STATUS, 32'd1);
    chk_rd("t4_clr_e13", A_STATUS, 32'd0);
    chk_pin("t4_intr_fall", K_INTR, 1'b0);

    // COUNT write on a tick edge
    step(1);
    chk_rd("t5_c_e14", A_COUNT, 32'd1);
    bus_wr(A_COUNT, 32'd10);
    chk_rd("t5_c_wr", A_COUNT, 32'd10);
    step(1);
    chk_rd("t5_c_e16", A_COUNT, 32'd10);
    step(1);
    chk_rd("t5_c_e17", A_COUNT, 32'd10);
    step(1);
    chk_rd("t5_c_e18", A_COUNT, 32'd9);
    bus_wr(A_CTRL, 32'h0000_0004);
    step(4);
    chk_rd("t5_stop_hold", A_COUNT, 32'd9);
    chk_rd("t5_stop_ctrl", A_CTRL, 32'h0000_0004);

    // Decode boundaries
    step(1);
    chk_rd("t6_unmapped14", BASE + 32'h14, 32'd0);
    chk_rd("t6_below", BASE - 32'd4, 32'd0);
    step(1);
    chk_rd("t6_unmapped1c", BASE + 32'h1C, 32'd0);
    chk_rd("t6_lowbits", BASE + 32'h07, 32'd1);
    bus_wr(BASE + 32'h24, 32'd55);
    chk_rd("t6_miss_wr", A_LOAD, 32'd1);

`ifdef OTTER_TMR_PWM_EN
    bus_wr(A_CMP, 32'd2);
    chk_rd("t6_cmp", A_CMP, 32'd2);
    bus_wr(A_LOAD, 32'd3);
    bus_wr(A_CTRL, 32'h0000_0003);
    chk_rd("t6_pwm_c3", A_COUNT, 32'd3);
    chk_pin("t6_pwm_e0", K_PWM, 1'b0);
    step(1);
    chk_pin("t6_pwm_e1", K_PWM, 1'b0);
    step(1);
    chk_pin("t6_pwm_e2", K_PWM, 1'b1);
    step(1);
    chk_pin("t6_pwm_e3", K_PWM, 1'b1);
    step(1);
    chk_rd("t6_pwm_c_e4", A_COUNT, 32'd3);
    chk_pin("t6_pwm_e4", K_PWM, 1'b0);
`else
    bus_wr(A_CMP, 32'd2);
    chk_rd("t6_cmp_absent", A_CMP, 32'd0);
    bus_wr(A_LOAD, 32'd3);
    bus_wr(A_CTRL, 32'h0000_0003);
    for (int i = 0; i < 5; i++) begin
      chk_pin("t6_pwm_off", K_PWM, 1'b0);
      step(1);
    end
`endif
    bus_wr(A_CTRL, 32'h0000_0000);
    step(1);

    #4;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
